// File: rtl/ifetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry {pc, instr} FIFO, 1-cycle latency (0 when IFQ_BYPASS_EN and empty).
// Backpressure: in_ready drops when full, from registered state only; flush empties the queue at the next edge.
module ifetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   logic            empty;
   logic            full;
   logic            enq;
   logic            deq;
   logic            pass;
   logic            wr_en;
   logic            rd_en;
   entry_t          head;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign in_ready = ~full;
   assign enq      = in_valid & in_ready;
   assign deq      = out_valid & out_ready;
   assign head     = mem[rd_ptr];

`ifdef IFQ_BYPASS_EN
   // An empty queue lets the fetched word fall straight through to decode.
   assign out_valid = (~empty | in_valid) & ~flush;
   assign out_pc    = empty ? in_pc    : head.pc;
   assign out_instr = empty ? in_instr : head.instr;
   assign pass      = empty & enq & out_ready;
`else
   assign out_valid = ~empty & ~flush;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign pass      = 1'b0;
`endif

   // A passed-through word is neither written nor popped from storage.
   assign wr_en = enq & ~pass & ~flush;
   assign rd_en = deq & ~pass & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_en & ~rd_en)
            count <= count + CNT_ONE;
         else if (rd_en & ~wr_en)
            count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
   end

   a_count_range: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && empty));
   a_head_stable: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !empty) |=> ($stable(out_pc) && $stable(out_instr)));

endmodule
